// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns an EX/MEM load/store into a data-memory handshake,
// stalls upstream while the access is outstanding, and presents a one-cycle writeback record.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic [31:0] Result_i,
  input  logic [31:0] rData2_i,
  input  logic [4:0]  wAddr_i,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic        wb_err,
  output logic [31:0] wb_result,
  output logic [31:0] wb_memdata,
  output logic [4:0]  wb_wAddr
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     addrReg;
  logic [31:0]     wdataReg;
  logic            weReg;
  logic            regWriteReg;
  logic [4:0]      wAddrReg;

  logic memOp;
  logic aligned;

  assign memOp   = MemRead_i | MemWrite_i;
  assign aligned = (Result_i[1:0] == 2'b00);

  // Stall must rise in the accepting IDLE cycle itself so upstream holds the instruction.
  assign stall    = ~rst & (((state == IDLE) & memOp & aligned) | (state == ACCESS));
  assign dm_req   = ~rst & (state == ACCESS);
  assign dm_we    = dm_req & weReg;
  assign dm_addr  = dm_req ? addrReg  : '0;
  assign dm_wdata = dm_req ? wdataReg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addrReg     <= '0;
      wdataReg    <= '0;
      weReg       <= 1'b0;
      regWriteReg <= 1'b0;
      wAddrReg    <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_err      <= 1'b0;
      wb_result   <= '0;
      wb_memdata  <= '0;
      wb_wAddr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp && aligned) begin
            addrReg     <= Result_i;
            wdataReg    <= rData2_i;
            weReg       <= MemWrite_i;
            regWriteReg <= RegWrite_i;
            wAddrReg    <= wAddr_i;
            cnt         <= '0;
            wb_valid    <= 1'b0;
            state       <= ACCESS;
          end else begin
            // Pass-through, or a misaligned access reported as an error without touching memory.
            wb_valid    <= 1'b1;
            wb_result   <= Result_i;
            wb_wAddr    <= wAddr_i;
            wb_memdata  <= '0;
            wb_err      <= memOp;
            wb_regwrite <= RegWrite_i & ~memOp;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            wb_valid    <= 1'b1;
            wb_result   <= addrReg;
            wb_wAddr    <= wAddrReg;
            wb_regwrite <= regWriteReg;
            wb_err      <= 1'b0;
            wb_memdata  <= weReg ? '0 : dm_rdata;
            state       <= DONE;
          end else if (cnt == CntLast) begin
            wb_valid    <= 1'b1;
            wb_result   <= addrReg;
            wb_wAddr    <= wAddrReg;
            wb_regwrite <= 1'b0;
            wb_err      <= 1'b1;
            wb_memdata  <= '0;
            state       <= DONE;
          end else begin
            cnt      <= cnt + 1'b1;
            wb_valid <= 1'b0;
          end
        end
        DONE: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized transactions
// compared against a transaction-level expectation of bus activity and writeback contents.
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_i, MemWrite_i, RegWrite_i;
  logic [31:0] Result_i, rData2_i;
  logic [4:0]  wAddr_i;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid, wb_regwrite, wb_err;
  logic [31:0] wb_result, wb_memdata;
  logic [4:0]  wb_wAddr;

  int checkCount = 0;
  int errCount   = 0;

  // Expected writeback record; expFull means result/wAddr are also defined.
  logic        expValid, expFull, expRegwrite, expErr;
  logic [31:0] expResult, expMemdata;
  logic [4:0]  expWAddr;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .Result_i(Result_i), .rData2_i(rData2_i), .wAddr_i(wAddr_i),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_err(wb_err),
    .wb_result(wb_result), .wb_memdata(wb_memdata), .wb_wAddr(wb_wAddr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkWb(input string ctx);
    checkVal({ctx, ".wb_valid"}, 32'(wb_valid), 32'(expValid));
    if (expValid || expFull) begin
      checkVal({ctx, ".wb_err"},      32'(wb_err),      32'(expErr));
      checkVal({ctx, ".wb_regwrite"}, 32'(wb_regwrite), 32'(expRegwrite));
      checkVal({ctx, ".wb_memdata"},  wb_memdata,       expMemdata);
      if (expFull) begin
        checkVal({ctx, ".wb_result"}, wb_result,     expResult);
        checkVal({ctx, ".wb_wAddr"},  32'(wb_wAddr), 32'(expWAddr));
      end
    end
  endtask

  task automatic checkBus(input string ctx, input logic expStall, input logic inAccess,
                          input logic [31:0] addr, input logic we, input logic [31:0] wd);
    checkVal({ctx, ".stall"},    32'(stall),  32'(expStall));
    checkVal({ctx, ".dm_req"},   32'(dm_req), 32'(inAccess));
    checkVal({ctx, ".dm_addr"},  dm_addr,     inAccess ? addr : 32'h0);
    checkVal({ctx, ".dm_we"},    32'(dm_we),  32'(inAccess & we));
    checkVal({ctx, ".dm_wdata"}, dm_wdata,    inAccess ? wd : 32'h0);
  endtask

  task automatic beginCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomizeInputs();
    MemRead_i  = 1'($urandom());
    MemWrite_i = 1'($urandom());
    RegWrite_i = 1'($urandom());
    Result_i   = $urandom();
    rData2_i   = $urandom();
    wAddr_i    = 5'($urandom());
    dm_ack     = 1'($urandom());
    dm_rdata   = $urandom();
  endtask

  task automatic setExpZero(input logic valid);
    expValid = valid; expFull = 1'b1; expRegwrite = 1'b0; expErr = 1'b0;
    expResult = '0; expMemdata = '0; expWAddr = '0;
  endtask

  // One instruction through the stage; ackAt = ACCESS cycle carrying dm_ack (>TO means never).
  task automatic runTxn(input string name, input logic rd, input logic wr, input logic rw,
                        input logic [31:0] res, input logic [31:0] wd, input logic [4:0] wa,
                        input int ackAt, input logic [31:0] rdata);
    logic memOp, aligned, acked;
    int   accCycles;
    memOp   = rd | wr;
    aligned = (res[1:0] == 2'b00);
    acked   = 1'b0;
    accCycles = 0;

    beginCycle();
    rst = 1'b0;
    MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw;
    Result_i = res; rData2_i = wd; wAddr_i = wa;
    dm_ack = 1'($urandom()); dm_rdata = $urandom();
    @(negedge clk);
    checkWb({name, ".idle"});
    checkBus({name, ".idle"}, memOp & aligned, 1'b0, 32'h0, 1'b0, 32'h0);

    if (!memOp) begin
      expValid = 1'b1; expFull = 1'b1; expRegwrite = rw; expErr = 1'b0;
      expResult = res; expMemdata = '0; expWAddr = wa;
    end else if (!aligned) begin
      expValid = 1'b1; expFull = 1'b0; expRegwrite = 1'b0; expErr = 1'b1; expMemdata = '0;
    end else begin
      expValid = 1'b0; expFull = 1'b0;
      for (int i = 1; i <= TO; i++) begin
        beginCycle();
        randomizeInputs();
        dm_ack   = (i == ackAt);
        dm_rdata = (i == ackAt) ? rdata : $urandom();
        @(negedge clk);
        accCycles++;
        checkWb({name, ".access"});
        checkBus({name, ".access"}, 1'b1, 1'b1, res, wr, wd);
        if (i == ackAt) begin
          acked = 1'b1;
          break;
        end
      end
      expValid    = 1'b1;
      expFull     = acked;
      expErr      = ~acked;
      expRegwrite = acked ? rw : 1'b0;
      expMemdata  = (acked && !wr) ? rdata : 32'h0;
      expResult   = res;
      expWAddr    = wa;

      beginCycle();
      randomizeInputs();
      @(negedge clk);
      checkWb({name, ".done"});
      checkBus({name, ".done"}, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      expValid = 1'b0; expFull = 1'b0;
    end
    $display("txn %s rd=%0b wr=%0b addr=0x%08h ackAt=%0d accessCycles=%0d", name, rd, wr, res,
             ackAt, accCycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int kind, sel, ackAt;

    rst = 1'b1;
    MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0;
    Result_i = '0; rData2_i = '0; wAddr_i = '0; dm_ack = 0; dm_rdata = '0;
    setExpZero(1'b0);

    // Reset holds stall and dm_req low even with an aligned request presented.
    for (int i = 0; i < 3; i++) begin
      beginCycle();
      randomizeInputs();
      MemRead_i = 1'b1; Result_i[1:0] = 2'b00;
      @(negedge clk);
      checkWb("reset");
      checkBus("reset", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    runTxn("pass",     0, 0, 1, 32'h10,  32'h0,        5'd5, 0,    32'h0);
    runTxn("read3",    1, 0, 1, 32'h100, 32'h0,        5'd7, 3,    32'hDEADBEEF);
    runTxn("write0",   0, 1, 0, 32'h204, 32'h12345678, 5'd0, 1,    32'h0);
    runTxn("misalign", 1, 0, 1, 32'h102, 32'h0,        5'd9, 1,    32'h0);
    runTxn("timeout",  1, 0, 1, 32'h40,  32'h0,        5'd3, TO+1, 32'h0);
    runTxn("both",     1, 1, 1, 32'h80,  32'hA5A5A5A5, 5'd4, 2,    32'h55AA55AA);
    runTxn("bubble",   0, 0, 0, 32'h0,   32'h0,        5'd0, 0,    32'h0);
    runTxn("ackLast",  1, 0, 1, 32'hC0,  32'h0,        5'd8, TO,   32'h13572468);

    // Reset in the second ACCESS cycle abandons the access; a late ack is ignored.
    beginCycle();
    rst = 1'b0; MemRead_i = 1; MemWrite_i = 0; RegWrite_i = 1;
    Result_i = 32'h300; rData2_i = 32'h0BADF00D; wAddr_i = 5'd11; dm_ack = 0;
    @(negedge clk);
    checkWb("rstacc.idle");
    checkBus("rstacc.idle", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    expValid = 1'b0; expFull = 1'b0;
    beginCycle();
    randomizeInputs(); dm_ack = 1'b0;
    @(negedge clk);
    checkBus("rstacc.acc1", 1'b1, 1'b1, 32'h300, 1'b0, 32'h0BADF00D);
    beginCycle();
    rst = 1'b1; dm_ack = 1'b0;
    @(negedge clk);
    checkWb("rstacc.rst");
    checkBus("rstacc.rst", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    setExpZero(1'b0);
    beginCycle();
    rst = 1'b0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0;
    Result_i = '0; rData2_i = '0; wAddr_i = '0; dm_ack = 1'b1; dm_rdata = 32'hFEEDFACE;
    @(negedge clk);
    checkWb("rstacc.after");
    checkBus("rstacc.after", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    setExpZero(1'b1);
    $display("txn rstacc addr=0x00000300 reset in ACCESS cycle 2");

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 3));
      res  = $urandom();
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      ackAt = int'($urandom_range(1, 4));
      else if (sel < 8) ackAt = int'($urandom_range(5, TO));
      else              ackAt = TO + 1;
      runTxn($sformatf("rnd%0d", n), kind[0], kind[1], 1'($urandom()), res, $urandom(),
             5'($urandom()), ackAt, $urandom());
    end

    beginCycle();
    rst = 1'b0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; dm_ack = 0;
    @(negedge clk);
    checkWb("final");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
